// File: rtl/fpu_job_dispatch.sv
// fpu_job_dispatch: FIFO of FPU jobs from the job manager, dispatched round-robin
// to NUM_FPU channels. Tracks per-channel busy state, retires NOOPs locally,
// flags bad ops and spurious completions, and counts finished jobs.
module fpu_job_dispatch #(
    parameter int NUM_FPU = 4,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 32,
    parameter int OP_W    = 6,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [OP_W-1:0]           job_op,
    input  logic [ADDR_W-1:0]         job_a,
    input  logic [ADDR_W-1:0]         job_b,
    input  logic [ADDR_W-1:0]         job_c,
    input  logic [ADDR_W-1:0]         job_d,
    output logic [NUM_FPU-1:0]        fpu_start,
    output logic [NUM_FPU*OP_W-1:0]   fpu_op,
    output logic [NUM_FPU*ADDR_W-1:0] fpu_a,
    output logic [NUM_FPU*ADDR_W-1:0] fpu_b,
    output logic [NUM_FPU*ADDR_W-1:0] fpu_c,
    output logic [NUM_FPU*ADDR_W-1:0] fpu_d,
    input  logic [NUM_FPU-1:0]        fpu_done,
    output logic [NUM_FPU-1:0]        busy,
    output logic [$clog2(DEPTH):0]    queue_count,
    output logic [CNT_W-1:0]          jobs_done,
    output logic                      err_bad_op,
    output logic                      err_spurious_done,
    output logic                      idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int QCW   = PTR_W + 1;
    localparam int GNT_W = (NUM_FPU > 1) ? $clog2(NUM_FPU) : 1;

    // Shared op_id encoding: NOOP is 0, PARAM_UPDATE (15) is the highest legal op.
    localparam logic [OP_W-1:0] OP_NOOP = '0;
    localparam logic [OP_W-1:0] OP_LAST = OP_W'(15);

    // Job FIFO payload
    logic [OP_W-1:0]   op_mem [DEPTH];
    logic [ADDR_W-1:0] a_mem  [DEPTH];
    logic [ADDR_W-1:0] b_mem  [DEPTH];
    logic [ADDR_W-1:0] c_mem  [DEPTH];
    logic [ADDR_W-1:0] d_mem  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              push;
    logic              pop;
    logic              head_valid;
    logic [OP_W-1:0]   head_op;
    logic              head_noop;
    logic              head_bad;
    logic              head_work;

    logic [GNT_W-1:0]  last_grant;
    logic [GNT_W-1:0]  grant_idx;
    logic              grant_any;
    logic              dispatch;
    logic [NUM_FPU-1:0] grant_vec;
    logic [NUM_FPU-1:0] done_hit;
    logic [NUM_FPU-1:0] done_spurious;
    logic [CNT_W-1:0]  done_add;
    int                rr_dist;
    int                rr_best;

    // Acceptance depends only on the registered count, so a same-cycle pop
    // never opens a slot in a full FIFO.
    assign job_ready  = (queue_count < QCW'(DEPTH));
    assign push       = job_valid && job_ready;

    assign head_valid = (queue_count != '0);
    assign head_op    = op_mem[rd_ptr];
    assign head_noop  = head_valid && (head_op == OP_NOOP);
    assign head_bad   = head_valid && (head_op > OP_LAST);
    assign head_work  = head_valid && !head_noop && !head_bad;

    assign dispatch   = head_work && grant_any;
    assign pop        = head_noop || head_bad || dispatch;

    assign done_hit      = fpu_done & busy;
    assign done_spurious = fpu_done & ~busy;

    assign idle = (queue_count == '0) && (busy == '0);

    // Round-robin pick: the idle channel closest after last_grant wins
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        rr_best   = NUM_FPU;
        rr_dist   = 0;
        grant_idx = '0;
        for (int i = 0; i < NUM_FPU; i++) begin
            rr_dist = (i + NUM_FPU - 1 - int'(last_grant)) % NUM_FPU;
            if (!busy[i] && (rr_dist < rr_best)) begin
                rr_best   = rr_dist;
                grant_idx = GNT_W'(i);
            end
        end
        grant_any = (rr_best < NUM_FPU);
    end

    // One-hot grant vector and completion count for this cycle
    always_comb begin
        grant_vec = '0;
        done_add  = '0;
        for (int i = 0; i < NUM_FPU; i++) begin
            grant_vec[i] = dispatch && (grant_idx == GNT_W'(i));
            if (done_hit[i]) begin
                done_add = done_add + CNT_W'(1);
            end
        end
    end

    // FIFO payload storage, written on accept
    // NOTE: payload memory has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            op_mem[wr_ptr] <= job_op;
            a_mem[wr_ptr]  <= job_a;
            b_mem[wr_ptr]  <= job_b;
            c_mem[wr_ptr]  <= job_c;
            d_mem[wr_ptr]  <= job_d;
        end
    end

    // Queue pointers, channel state, counters and sticky error flags
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            queue_count       <= '0;
            busy              <= '0;
            fpu_start         <= '0;
            last_grant        <= GNT_W'(NUM_FPU - 1);
            jobs_done         <= '0;
            err_bad_op        <= 1'b0;
            err_spurious_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            queue_count <= queue_count + QCW'(push) - QCW'(pop);
            // A granted channel was idle, so it cannot also be cleared by done here.
            busy        <= (busy & ~done_hit) | grant_vec;
            fpu_start   <= grant_vec;
            if (dispatch) begin
                last_grant <= grant_idx;
            end
            jobs_done         <= jobs_done + done_add + CNT_W'(head_noop);
            err_bad_op        <= err_bad_op | head_bad;
            err_spurious_done <= err_spurious_done | (|done_spurious);
        end
    end

    // Per-channel job outputs, latched on dispatch and held until the next one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fpu_op <= '0;
            fpu_a  <= '0;
            fpu_b  <= '0;
            fpu_c  <= '0;
            fpu_d  <= '0;
        end else begin
            for (int i = 0; i < NUM_FPU; i++) begin
                if (grant_vec[i]) begin
                    fpu_op[i*OP_W +: OP_W]     <= head_op;
                    fpu_a[i*ADDR_W +: ADDR_W]  <= a_mem[rd_ptr];
                    fpu_b[i*ADDR_W +: ADDR_W]  <= b_mem[rd_ptr];
                    fpu_c[i*ADDR_W +: ADDR_W]  <= c_mem[rd_ptr];
                    fpu_d[i*ADDR_W +: ADDR_W]  <= d_mem[rd_ptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_job_dispatch.sv
// Testbench for fpu_job_dispatch: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_fpu_job_dispatch;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int OW    = 6;
    localparam int CW    = 16;

    typedef struct {
        logic [OW-1:0] op;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
        logic [AW-1:0] d;
    } job_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              job_valid;
    logic              job_ready;
    logic [OW-1:0]     job_op;
    logic [AW-1:0]     job_a, job_b, job_c, job_d;
    logic [N-1:0]      fpu_start;
    logic [N*OW-1:0]   fpu_op;
    logic [N*AW-1:0]   fpu_a, fpu_b, fpu_c, fpu_d;
    logic [N-1:0]      fpu_done;
    logic [N-1:0]      busy;
    logic [$clog2(DEPTH):0] queue_count;
    logic [CW-1:0]     jobs_done;
    logic              err_bad_op;
    logic              err_spurious_done;
    logic              idle;

    fpu_job_dispatch #(
        .NUM_FPU(N), .DEPTH(DEPTH), .ADDR_W(AW), .OP_W(OW), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
        .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d),
        .fpu_start(fpu_start), .fpu_op(fpu_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_d(fpu_d),
        .fpu_done(fpu_done), .busy(busy), .queue_count(queue_count),
        .jobs_done(jobs_done), .err_bad_op(err_bad_op),
        .err_spurious_done(err_spurious_done), .idle(idle)
    );

    always #5 clock = ~clock;

    // Reference model state
    job_t mq[$];
    bit   m_busy  [N];
    bit   m_start [N];
    job_t m_ch    [N];
    int   m_lg;
    int   m_jd;
    bit   m_bad;
    bit   m_spur;
    bit   last_accept;

    int vectors     = 0;
    int miscompares = 0;

    job_t nil_job;
    job_t jobs [16];

    function automatic job_t mk(input int op, input logic [AW-1:0] a, b, c, d);
        job_t j;
        j.op = OW'(op); j.a = a; j.b = b; j.c = c; j.d = d;
        return j;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < N; i++) begin
            m_busy[i]  = 1'b0;
            m_start[i] = 1'b0;
            m_ch[i]    = mk(0, 0, 0, 0, 0);
        end
        m_lg = N - 1; m_jd = 0; m_bad = 1'b0; m_spur = 1'b0;
    endtask

    // One clock edge of the specified behaviour, from pre-edge state
    task automatic model_edge(input bit v, input job_t j, input logic [N-1:0] done);
        bit   pre_busy [N];
        bit   accept;
        int   g;
        int   c;
        job_t h;
        accept = v && (mq.size() < DEPTH);
        for (int i = 0; i < N; i++) begin
            pre_busy[i] = m_busy[i];
            m_start[i]  = 1'b0;
        end
        if (mq.size() > 0) begin
            h = mq[0];
            if (h.op == 0) begin
                void'(mq.pop_front());
                m_jd++;
            end else if (h.op > 15) begin
                void'(mq.pop_front());
                m_bad = 1'b1;
            end else begin
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_lg + k) % N;
                    if (g < 0 && !pre_busy[c]) g = c;
                end
                if (g >= 0) begin
                    void'(mq.pop_front());
                    m_ch[g] = h; m_busy[g] = 1'b1; m_start[g] = 1'b1; m_lg = g;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                if (pre_busy[i]) begin
                    m_busy[i] = 1'b0;
                    m_jd++;
                end else begin
                    m_spur = 1'b1;
                end
            end
        end
        if (accept) mq.push_back(j);
        last_accept = accept;
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0]    eb, es;
        logic [N*OW-1:0] eop;
        logic [N*AW-1:0] ea, eb_h, ec, ed;
        logic [CW-1:0]   ejd;
        for (int i = 0; i < N; i++) begin
            eb[i] = m_busy[i];
            es[i] = m_start[i];
            eop[i*OW +: OW]  = m_ch[i].op;
            ea[i*AW +: AW]   = m_ch[i].a;
            eb_h[i*AW +: AW] = m_ch[i].b;
            ec[i*AW +: AW]   = m_ch[i].c;
            ed[i*AW +: AW]   = m_ch[i].d;
        end
        ejd = CW'(m_jd);
        check({tag, ".ready"}, job_ready, (mq.size() < DEPTH));
        check({tag, ".qcount"}, queue_count, mq.size());
        check({tag, ".busy"}, busy, eb);
        check({tag, ".start"}, fpu_start, es);
        check({tag, ".jobs_done"}, jobs_done, ejd);
        check({tag, ".err_bad"}, err_bad_op, m_bad);
        check({tag, ".err_spur"}, err_spurious_done, m_spur);
        check({tag, ".idle"}, idle, (mq.size() == 0) && (eb == '0));
        check({tag, ".op"}, fpu_op, eop);
        check({tag, ".a"}, fpu_a, ea);
        check({tag, ".b"}, fpu_b, eb_h);
        check({tag, ".c"}, fpu_c, ec);
        check({tag, ".d"}, fpu_d, ed);
    endtask

    // Drive one cycle of inputs, advance the model, compare after the edge
    task automatic step(input bit v, input job_t j, input logic [N-1:0] done, input string tag);
        job_valid = v;
        job_op = j.op; job_a = j.a; job_b = j.b; job_c = j.c; job_d = j.d;
        fpu_done = done;
        model_edge(v, j, done);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset placed between edges; outputs checked while held low
    task automatic do_reset(input string tag);
        #2;
        reset_n   = 1'b0;
        job_valid = 1'b0;
        fpu_done  = '0;
        model_reset();
        #1;
        check_all(tag);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int           idx;
        int           r;
        logic [N-1:0] dn;
        bit           v;
        job_t         j;

        nil_job   = mk(0, 0, 0, 0, 0);
        reset_n   = 1'b0;
        job_valid = 1'b0;
        fpu_done  = '0;
        job_op = '0; job_a = '0; job_b = '0; job_c = '0; job_d = '0;
        model_reset();
        @(posedge clock);
        #1;

        // Single LINEAR_FW job on channel 0
        do_reset("t1_rst");
        step(1, mk(1, 'h100, 'h200, 'h300, 'h400), '0, "t1_push");
        step(0, nil_job, '0, "t1_disp");
        check("t1_start0", fpu_start, 4'b0001);
        check("t1_op0", fpu_op[OW-1:0], 1);
        check("t1_a0", fpu_a[AW-1:0], 'h100);
        check("t1_d0", fpu_d[AW-1:0], 'h400);
        step(0, nil_job, '0, "t1_hold");
        step(0, nil_job, 4'b0001, "t1_done");
        check("t1_jobs_done", jobs_done, 1);
        check("t1_idle", idle, 1);
        check("t1_busy", busy, 0);

        // Six jobs, four channels, then targeted completions
        do_reset("t2_rst");
        for (int k = 0; k < 6; k++) begin
            jobs[k] = mk(k + 1, $urandom, $urandom, $urandom, $urandom);
            step(1, jobs[k], '0, "t2_push");
        end
        step(0, nil_job, '0, "t2_stall");
        check("t2_qcount", queue_count, 2);
        check("t2_nostart", fpu_start, 0);
        step(0, nil_job, 4'b0100, "t2_done2");
        step(0, nil_job, '0, "t2_disp2");
        check("t2_start2", fpu_start, 4'b0100);
        check("t2_op2", fpu_op[2*OW +: OW], 5);
        step(0, nil_job, 4'b0001, "t2_done0");
        step(0, nil_job, '0, "t2_disp0");
        check("t2_start0", fpu_start, 4'b0001);
        check("t2_op0", fpu_op[OW-1:0], 6);

        // Fill the FIFO while all channels are busy
        do_reset("t3_rst");
        for (int k = 0; k < 4; k++) step(1, mk(k + 1, k, k, k, k), '0, "t3_fill");
        for (int k = 0; k < 2; k++) step(0, nil_job, '0, "t3_settle");
        for (int k = 0; k < 9; k++) jobs[k] = mk(k + 2, $urandom, $urandom, $urandom, $urandom);
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 8; cyc++) begin
            step(1, jobs[idx], '0, "t3_push");
            if (last_accept) idx++;
        end
        check("t3_full_ready", job_ready, 0);
        check("t3_full_count", queue_count, DEPTH);
        step(1, jobs[8], '0, "t3_held");
        step(1, jobs[8], 4'b0001, "t3_done");
        step(1, jobs[8], '0, "t3_disp");
        check("t3_disp_start", fpu_start, 4'b0001);
        check("t3_ready_again", job_ready, 1);
        step(1, jobs[8], '0, "t3_accept9");
        check("t3_count9", queue_count, DEPTH);
        step(0, nil_job, '0, "t3_idle");

        // NOOP interleaved between real jobs
        do_reset("t4_rst");
        step(1, mk(1, 1, 2, 3, 4), '0, "t4_push1");
        step(1, mk(0, 9, 9, 9, 9), '0, "t4_push0");
        step(1, mk(5, 5, 6, 7, 8), '0, "t4_push5");
        for (int k = 0; k < 3; k++) step(0, nil_job, '0, "t4_drain");
        check("t4_jobs_done", jobs_done, 1);
        check("t4_busy", busy, 4'b0011);
        check("t4_op_ch1", fpu_op[OW +: OW], 5);

        // Bad op and a spurious done
        step(1, mk(20, 1, 1, 1, 1), '0, "t5_push_bad");
        step(0, nil_job, '0, "t5_pop_bad");
        check("t5_err_bad", err_bad_op, 1);
        check("t5_jobs_done", jobs_done, 1);
        step(0, nil_job, 4'b1000, "t5_spur");
        check("t5_err_spur", err_spurious_done, 1);
        check("t5_busy", busy, 4'b0011);
        step(0, nil_job, '0, "t5_sticky");
        check("t5_err_bad_sticky", err_bad_op, 1);

        // Reset with three busy channels and four queued jobs
        do_reset("t6_rst");
        for (int k = 0; k < 4; k++) step(1, mk(k + 1, k, k, k, k), '0, "t6_fill");
        for (int k = 0; k < 4; k++) step(1, mk(k + 7, k, k, k, k), '0, "t6_queue");
        step(0, nil_job, 4'b1000, "t6_free3");
        do_reset("t6_midrst");
        check("t6_busy_rst", busy, 0);
        check("t6_count_rst", queue_count, 0);
        step(1, mk(3, 'h30, 'h31, 'h32, 'h33), '0, "t6_push");
        step(0, nil_job, '0, "t6_disp");
        check("t6_start0", fpu_start, 4'b0001);

        // Randomized traffic
        do_reset("rnd_rst");
        for (int cyc = 0; cyc < 500; cyc++) begin
            v = ($urandom % 4) != 0;
            r = $urandom % 16;
            if (r < 2)       j = mk(0, $urandom, $urandom, $urandom, $urandom);
            else if (r == 2) j = mk(16 + ($urandom % 48), $urandom, $urandom, $urandom, $urandom);
            else             j = mk(1 + ($urandom % 15), $urandom, $urandom, $urandom, $urandom);
            for (int i = 0; i < N; i++) begin
                dn[i] = m_busy[i] ? (($urandom % 3) == 0) : (($urandom % 64) == 0);
            end
            step(v, j, dn, "rnd");
        end

        // Drain: complete everything still running, bounded
        for (int cyc = 0; cyc < 100 && !(mq.size() == 0 && !m_busy[0] && !m_busy[1] && !m_busy[2] && !m_busy[3]); cyc++) begin
            for (int i = 0; i < N; i++) dn[i] = m_busy[i];
            step(0, nil_job, dn, "drain");
        end
        check("drain_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
